// File: rtl/hafsa_sopc_buttons.sv
// hafsa_sopc_buttons: debounced push-button / switch input port with edge
// capture and a level interrupt, exposed as a zero-wait-state Avalon-MM slave.
// Register map: 0 debounced data (RO), 1 reserved, 2 irqmask, 3 edgecapture (RW1C).
// WIDTH is expected to be at most 32.
module hafsa_sopc_buttons #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clear_mask;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning; the rest are dropped.
  assign unused_wdata = ^writedata;

  assign wr_en      = chipselect & ~write_n;
  assign clear_mask = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // Per-bit debounce: a bit is accepted once the synchronized value has
  // disagreed with the stable value for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync_q[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync_q[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Qualify changes of the debounced value against the configured edge type.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_event = stable_next & ~stable;
      1:       edge_event = ~stable_next & stable;
      default: edge_event = stable_next ^ stable;
    endcase
  end

  // State update; a new edge wins over a same-cycle clear of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta   <= '0;
      sync_q      <= '0;
      stable      <= '0;
      cnt         <= '{default: '0};
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      sync_meta   <= in_port;
      sync_q      <= sync_meta;
      stable      <= stable_next;
      cnt         <= cnt_next;
      edgecapture <= (edgecapture & ~clear_mask) | edge_event;
      if (wr_en && address == ADDR_MASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_MASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edgecapture;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_hafsa_sopc_buttons.sv
// Testbench for hafsa_sopc_buttons: directed stimulus, a window-based
// behavioural model checked every cycle, plus literal spot checks.
module tb_hafsa_sopc_buttons;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int ET = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  hafsa_sopc_buttons #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .EDGE_TYPE(ET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #10 clk = ~clk;

  // Model state: hist[j] holds in_port as sampled j+1 edges ago.
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_ec     = '0;
  logic [W-1:0] m_mask   = '0;
  logic [W-1:0] hist [0:D];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: a bit flips once its last D synchronized samples all disagree with it.
  initial begin
    logic [W-1:0] nxt;
    logic [W-1:0] ev;
    logic [W-1:0] clr;
    bit all_diff;
    for (int j = 0; j <= D; j++) hist[j] = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_stable = '0;
        m_ec     = '0;
        m_mask   = '0;
        for (int j = 0; j <= D; j++) hist[j] = '0;
      end else begin
        nxt = m_stable;
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++)
            if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = ~m_stable[b];
        end
        if (ET == 0)      ev = nxt & ~m_stable;
        else if (ET == 1) ev = ~nxt & m_stable;
        else              ev = nxt ^ m_stable;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ec = (m_ec & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_stable = nxt;
        for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
      end
    end
  end

  // Every-cycle comparison of the bus view and irq against the model.
  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      case (address)
        2'd0:    exp_rd = {{(32-W){1'b0}}, m_stable};
        2'd2:    exp_rd = {{(32-W){1'b0}}, m_mask};
        2'd3:    exp_rd = {{(32-W){1'b0}}, m_ec};
        default: exp_rd = '0;
      endcase
      check("cyc_readdata", readdata, exp_rd);
      check("cyc_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;

    // Reset for two cycles, everything reads zero.
    tick(2);
    reset = 1'b0;
    rd_chk("rst_addr0", 2'd0, 32'h0);
    rd_chk("rst_addr1", 2'd1, 32'h0);
    rd_chk("rst_addr2", 2'd2, 32'h0);
    rd_chk("rst_addr3", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(2);

    // 0x00 -> 0x05: visible on the sixth edge, not the fifth.
    in_port = 8'h05;
    address = 2'd0;
    tick(5);
    rd_chk("lat_edge5", 2'd0, 32'h0);
    tick(1);
    rd_chk("lat_edge6", 2'd0, 32'h05);
    rd_chk("lat_edgecap", 2'd3, 32'h05);
    check("lat_irq_masked", {31'b0, irq}, 32'h0);

    // Writes to data/reserved addresses have no effect.
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("ro_addr0", 2'd0, 32'h05);
    rd_chk("ro_addr1", 2'd1, 32'h0);

    // Mask load ignores upper bits; RW1C clearing.
    bus_wr(2'd2, 32'hABCD_EF04);
    rd_chk("mask_load", 2'd2, 32'h04);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_wr(2'd3, 32'h0000_0004);
    rd_chk("w1c_bit2", 2'd3, 32'h01);
    check("irq_clr", {31'b0, irq}, 32'h0);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("w1c_all", 2'd3, 32'h0);

    // Drop bit 2 (falling edge is not captured), then glitch tests.
    in_port = 8'h01;
    tick(8);
    rd_chk("fall_data", 2'd0, 32'h01);
    rd_chk("fall_nocap", 2'd3, 32'h0);
    in_port = 8'h05;
    tick(3);
    in_port = 8'h01;
    tick(8);
    rd_chk("glitch3_data", 2'd0, 32'h01);
    rd_chk("glitch3_cap", 2'd3, 32'h0);
    check("glitch3_irq", {31'b0, irq}, 32'h0);
    in_port = 8'h05;
    tick(4);
    in_port = 8'h01;
    tick(2);
    rd_chk("pulse4_data", 2'd0, 32'h05);
    tick(8);
    rd_chk("pulse4_back", 2'd0, 32'h01);
    rd_chk("pulse4_cap", 2'd3, 32'h04);
    check("pulse4_irq", {31'b0, irq}, 32'h1);

    // Clear of bit 1 on the very edge where it rises: set wins.
    bus_wr(2'd3, 32'h0000_00FF);
    in_port = 8'h03;
    tick(5);
    bus_wr(2'd3, 32'h0000_0002);
    rd_chk("race_cap", 2'd3, 32'h02);
    rd_chk("race_data", 2'd0, 32'h03);
    check("race_irq", {31'b0, irq}, 32'h0);

    // Reset two cycles into a debounce of bit 7, with a mask write racing it.
    in_port = 8'h83;
    tick(4);
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd2;
    writedata  = 32'h0000_00FF;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick(1);
    rd_chk("mid_rst_addr0", 2'd0, 32'h0);
    rd_chk("mid_rst_addr2", 2'd2, 32'h0);
    rd_chk("mid_rst_addr3", 2'd3, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    reset   = 1'b0;
    address = 2'd0;
    tick(5);
    rd_chk("post_rst_edge5", 2'd0, 32'h0);
    tick(1);
    rd_chk("post_rst_edge6", 2'd0, 32'h83);
    rd_chk("post_rst_cap", 2'd3, 32'h83);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
